// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic result drain stage.
// Default sizes, FSM state encoding and index-width helper.
package systolic_result_drain_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_N_SIZE    = 5;
    localparam int DEF_OUT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Width of a row/column index; never zero so N_SIZE==1 still has a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_drain_saturate.sv
// Unsigned narrowing of one result element.
// Clips to all ones when the value does not fit, else passes it through.
module systolic_result_drain_saturate #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    if (OUT_W >= IN_W) begin : g_ext
        assign data_o = OUT_W'(data_i);
        assign sat_o  = 1'b0;
    end else begin : g_clip
        logic over;
        assign over   = |data_i[IN_W-1:OUT_W];
        assign data_o = over ? {OUT_W{1'b1}} : data_i[OUT_W-1:0];
        assign sat_o  = over;
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures N_SIZE result rows from the array into a local buffer,
// then streams the elements row-major over valid/ready, narrowed.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int N_SIZE    = DEF_N_SIZE,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    localparam int CW = 2 * DATAWIDTH,
    localparam int IW = idx_w(N_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    input  logic [N_SIZE*CW-1:0]   row_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [IW-1:0]          out_row,
    output logic [IW-1:0]          out_col,
    output logic                   out_last,
    output logic                   out_sat,
    output logic                   busy,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    localparam logic [IW-1:0] LAST = IW'(N_SIZE - 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         cap_q, cap_d;
    logic [IW-1:0]         row_q, row_d;
    logic [IW-1:0]         col_q, col_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_en;
    logic [IW-1:0]         wr_row;
    logic [N_SIZE*CW-1:0]  mem_q [N_SIZE];
    logic [N_SIZE*CW-1:0]  rd_row;
    logic [CW-1:0]         elem;
    logic [OUT_WIDTH-1:0]  sat_data;
    logic                  sat_flag;
    logic                  drain;
    logic                  at_last;

    assign drain   = (state_q == DRAIN);
    assign at_last = (row_q == LAST) && (col_q == LAST);

    // Next state, capture/drain counters and buffer write select.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        row_d   = row_q;
        col_d   = col_q;
        wr_en   = 1'b0;
        wr_row  = cap_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    wr_en  = 1'b1;
                    wr_row = '0;
                    if (N_SIZE == 1) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = CAPTURE;
                        cap_d   = IW'(1);
                    end
                end
            end
            CAPTURE: begin
                if (valid_in) begin
                    wr_en = 1'b1;
                    if (cap_q == LAST) begin
                        state_d = DRAIN;
                        cap_d   = '0;
                    end else begin
                        cap_d = cap_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cap_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // Sticky drop flag: a row arriving while draining wins over clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_overflow) ovf_d = 1'b0;
        if (drain && valid_in) ovf_d = 1'b1;
    end

    // Control state with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result buffer; contents are don't-care until rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_row] <= row_in;
    end

    assign rd_row = mem_q[row_q];

    // Column select within the current drain row.
    always_comb begin
        elem = '0;
        for (int j = 0; j < N_SIZE; j++) begin
            if (col_q == IW'(j)) elem = rd_row[j*CW +: CW];
        end
    end

    systolic_result_drain_saturate #(
        .IN_W  (CW),
        .OUT_W (OUT_WIDTH)
    ) u_sat (
        .data_i (elem),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    assign out_valid = drain;
    assign out_data  = drain ? sat_data : '0;
    assign out_row   = drain ? row_q : '0;
    assign out_col   = drain ? col_q : '0;
    assign out_last  = drain & at_last;
    assign out_sat   = drain & sat_flag;
    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (N_SIZE=2).
// Two instances: 16-bit output (pass-through) and 12-bit output (clipping).
module tb_systolic_result_drain;

    localparam int DW = 8;
    localparam int N  = 2;
    localparam int CW = 2 * DW;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_in = 1'b0;
    logic            out_ready = 1'b0;
    logic            clear_overflow = 1'b0;
    logic [N*CW-1:0] row_in = '0;

    logic            out_valid, out_last, out_sat, busy, overflow;
    logic [15:0]     out_data;
    logic [IW-1:0]   out_row, out_col;

    logic            v12, last12, sat12, busy12, ovf12;
    logic [11:0]     d12;
    logic [IW-1:0]   r12, c12;

    systolic_result_drain #(
        .DATAWIDTH (DW), .N_SIZE (N), .OUT_WIDTH (16)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .valid_in (valid_in), .row_in (row_in),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_row (out_row), .out_col (out_col), .out_last (out_last),
        .out_sat (out_sat), .busy (busy), .overflow (overflow),
        .clear_overflow (clear_overflow)
    );

    systolic_result_drain #(
        .DATAWIDTH (DW), .N_SIZE (N), .OUT_WIDTH (12)
    ) u_dut12 (
        .clk (clk), .rst_n (rst_n), .valid_in (valid_in), .row_in (row_in),
        .out_valid (v12), .out_ready (out_ready), .out_data (d12),
        .out_row (r12), .out_col (c12), .out_last (last12),
        .out_sat (sat12), .busy (busy12), .overflow (ovf12),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   d;
        logic [IW-1:0] r;
        logic [IW-1:0] c;
        logic          last;
        logic          sat;
        logic [11:0]   d12;
        logic          s12;
        logic [IW-1:0] r12;
        logic [IW-1:0] c12;
        logic          last12;
    } beat_t;

    int          chk = 0;
    int          err = 0;
    logic [15:0] mat [N][N];
    beat_t       obs [$];
    int          stab_err;
    int          ncyc;
    bit          tmo;

    // Reference: element k of the row-major stream of the current matrix.
    function automatic beat_t exp_beat(input int k);
        beat_t       b;
        int          r, c;
        logic [15:0] e;
        r = k / N;
        c = k % N;
        e = mat[r][c];
        b.d      = e;
        b.r      = IW'(r);
        b.c      = IW'(c);
        b.last   = (k == N * N - 1);
        b.sat    = 1'b0;
        b.s12    = (e > 16'd4095);
        b.d12    = b.s12 ? 12'hFFF : e[11:0];
        b.r12    = IW'(r);
        b.c12    = IW'(c);
        b.last12 = b.last;
        return b;
    endfunction

    task automatic rand_mat();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = $urandom_range(0, 1) ? 16'($urandom)
                                                 : 16'($urandom_range(0, 4095));
    endtask

    // Drives the matrix rows; returns #1 into the first DRAIN cycle.
    task automatic send_burst(input int gap);
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) begin
            valid_in = 1'b1;
            for (int j = 0; j < N; j++) row_in[j*CW +: CW] = mat[r][j];
            @(posedge clk); #1;
            valid_in = 1'b0;
            if (r < N - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // Records accepted beats and hold violations; mode 0 ready=1,
    // 1 pattern 1,0,0 repeating, 2 random.
    task automatic collect(input int mode, input int budget);
        beat_t pv;
        bit    hold;
        bit    done;
        beat_t b;
        obs.delete();
        stab_err = 0;
        ncyc = 0;
        hold = 0;
        done = 0;
        pv = '0;
        while (!done && ncyc < budget) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (ncyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            b = '{d: out_data, r: out_row, c: out_col, last: out_last,
                  sat: out_sat, d12: d12, s12: sat12, r12: r12, c12: c12,
                  last12: last12};
            if (v12 !== out_valid) stab_err++;
            if (hold && (!out_valid || b !== pv)) stab_err++;
            hold = out_valid && !out_ready;
            pv = b;
            if (out_valid && out_ready) begin
                obs.push_back(b);
                if (out_last) done = 1;
            end
            @(posedge clk); #1;
            ncyc++;
        end
        out_ready = 1'b0;
        tmo = !done;
    endtask

    task automatic test_reset();
        #2;
        chk++;
        if ({out_valid, out_data, out_row, out_col, out_last, out_sat}
            !== '0) begin
            err++;
            $display("FAIL reset_out: got %h exp 0",
                     {out_valid, out_data, out_row, out_col, out_last, out_sat});
        end
        chk++;
        if ({busy, overflow, busy12, ovf12, v12, d12} !== '0) begin
            err++;
            $display("FAIL reset_status: got %h exp 0",
                     {busy, overflow, busy12, ovf12, v12, d12});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        mat[0][0] = 16'd1; mat[0][1] = 16'd2;
        mat[1][0] = 16'd3; mat[1][1] = 16'd4;
        send_burst(0);
        chk++;
        if ({out_valid, busy, out_data} !== {1'b1, 1'b1, 16'd1}) begin
            err++;
            $display("FAIL b2b_first: got %h exp %h",
                     {out_valid, busy, out_data}, {1'b1, 1'b1, 16'd1});
        end
        collect(0, 50);
        chk++;
        if (tmo || obs.size() != N * N || ncyc != N * N) begin
            err++;
            $display("FAIL b2b_count: got beats %0d cycles %0d tmo %0d exp %0d",
                     obs.size(), ncyc, tmo, N * N);
        end
        for (int k = 0; k < obs.size() && k < N * N; k++) begin
            chk++;
            if (obs[k] !== exp_beat(k)) begin
                err++;
                $display("FAIL b2b_beat%0d: got %h exp %h",
                         k, obs[k], exp_beat(k));
            end
        end
        chk++;
        if ({busy, out_valid, out_data} !== '0) begin
            err++;
            $display("FAIL b2b_idle: got %h exp 0", {busy, out_valid, out_data});
        end
    endtask

    task automatic test_ready_toggle();
        send_burst(0);
        collect(1, 60);
        chk++;
        if (tmo || obs.size() != N * N || stab_err != 0) begin
            err++;
            $display("FAIL toggle_count: got beats %0d holderr %0d tmo %0d exp %0d",
                     obs.size(), stab_err, tmo, N * N);
        end
        for (int k = 0; k < obs.size() && k < N * N; k++) begin
            chk++;
            if (obs[k] !== exp_beat(k)) begin
                err++;
                $display("FAIL toggle_beat%0d: got %h exp %h",
                         k, obs[k], exp_beat(k));
            end
        end
    endtask

    task automatic test_gap();
        send_burst(2);
        collect(0, 50);
        chk++;
        if (tmo || obs.size() != N * N || stab_err != 0) begin
            err++;
            $display("FAIL gap_count: got beats %0d tmo %0d exp %0d",
                     obs.size(), tmo, N * N);
        end
        for (int k = 0; k < obs.size() && k < N * N; k++) begin
            chk++;
            if (obs[k] !== exp_beat(k)) begin
                err++;
                $display("FAIL gap_beat%0d: got %h exp %h",
                         k, obs[k], exp_beat(k));
            end
        end
    endtask

    task automatic test_saturate();
        mat[0][0] = 16'hFFFF; mat[0][1] = 16'h0ABC;
        mat[1][0] = 16'h1000; mat[1][1] = 16'h0FFF;
        send_burst(0);
        collect(2, 100);
        chk++;
        if (tmo || obs.size() != N * N) begin
            err++;
            $display("FAIL sat_count: got %0d tmo %0d exp %0d",
                     obs.size(), tmo, N * N);
        end else begin
            chk++;
            if ({obs[0].d12, obs[0].s12} !== {12'hFFF, 1'b1}) begin
                err++;
                $display("FAIL sat_clip: got %h/%b exp fff/1",
                         obs[0].d12, obs[0].s12);
            end
            chk++;
            if ({obs[1].d12, obs[1].s12} !== {12'hABC, 1'b0}) begin
                err++;
                $display("FAIL sat_pass: got %h/%b exp abc/0",
                         obs[1].d12, obs[1].s12);
            end
        end
        for (int k = 0; k < obs.size() && k < N * N; k++) begin
            chk++;
            if (obs[k] !== exp_beat(k)) begin
                err++;
                $display("FAIL sat_beat%0d: got %h exp %h",
                         k, obs[k], exp_beat(k));
            end
        end
    endtask

    task automatic test_overflow();
        rand_mat();
        send_burst(0);
        out_ready = 1'b0;
        valid_in = 1'b1;
        row_in = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk++;
        if ({overflow, out_valid, out_row, out_col} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
            err++;
            $display("FAIL ovf_set: got %b exp 1100",
                     {overflow, out_valid, out_row, out_col});
        end
        collect(0, 50);
        chk++;
        if (tmo || obs.size() != N * N) begin
            err++;
            $display("FAIL ovf_count: got %0d exp %0d", obs.size(), N * N);
        end
        for (int k = 0; k < obs.size() && k < N * N; k++) begin
            chk++;
            if (obs[k] !== exp_beat(k)) begin
                err++;
                $display("FAIL ovf_beat%0d: got %h exp %h",
                         k, obs[k], exp_beat(k));
            end
        end
        chk++;
        if (overflow !== 1'b1) begin
            err++;
            $display("FAIL ovf_sticky: got %b exp 1", overflow);
        end
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        chk++;
        if (overflow !== 1'b0) begin
            err++;
            $display("FAIL ovf_clear: got %b exp 0", overflow);
        end
        rand_mat();
        send_burst(0);
        valid_in = 1'b1;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        clear_overflow = 1'b0;
        chk++;
        if (overflow !== 1'b1) begin
            err++;
            $display("FAIL ovf_set_wins: got %b exp 1", overflow);
        end
        clear_overflow = 1'b1;
        out_ready = 1'b1;
        repeat (N * N - 1) begin @(posedge clk); #1; end
        clear_overflow = 1'b0;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        out_ready = 1'b0;
        chk++;
        if ({busy, overflow} !== 2'b01) begin
            err++;
            $display("FAIL ovf_last_drop: got busy/ovf %b exp 01", {busy, overflow});
        end
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
    endtask

    task automatic test_reset_mid();
        rand_mat();
        send_burst(0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk++;
        if ({out_valid, out_row, out_col} !== 3'b101) begin
            err++;
            $display("FAIL rst_pre: got %b exp 101", {out_valid, out_row, out_col});
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk++;
        if ({out_valid, out_data, out_row, out_col, out_last, out_sat, busy,
             v12, busy12} !== '0) begin
            err++;
            $display("FAIL rst_abort: got %h exp 0",
                     {out_valid, out_data, out_row, out_col, out_last, out_sat,
                      busy, v12, busy12});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_mat();
        send_burst(0);
        collect(2, 100);
        chk++;
        if (tmo || obs.size() != N * N || stab_err != 0) begin
            err++;
            $display("FAIL rst_count: got %0d tmo %0d exp %0d",
                     obs.size(), tmo, N * N);
        end
        for (int k = 0; k < obs.size() && k < N * N; k++) begin
            chk++;
            if (obs[k] !== exp_beat(k)) begin
                err++;
                $display("FAIL rst_beat%0d: got %h exp %h",
                         k, obs[k], exp_beat(k));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            rand_mat();
            send_burst($urandom_range(0, 2));
            collect(2, 200);
            chk++;
            if (tmo || obs.size() != N * N || stab_err != 0) begin
                err++;
                $display("FAIL rand%0d_count: got %0d hold %0d tmo %0d exp %0d",
                         it, obs.size(), stab_err, tmo, N * N);
            end
            for (int k = 0; k < obs.size() && k < N * N; k++) begin
                chk++;
                if (obs[k] !== exp_beat(k)) begin
                    err++;
                    $display("FAIL rand%0d_beat%0d: got %h exp %h",
                             it, k, obs[k], exp_beat(k));
                end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ready_toggle();
        test_gap();
        test_saturate();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
